// File: rtl/rotator_seq.sv
`timescale 1ns/1ps
// rotator_seq: time-multiplexed dual-input phase rotator.
// On a symbol strobe two complex samples are captured and multiplied against
// an NUM_PTS-entry phase table through a 3-stage pipelined complex multiplier.
// Each output beat carries lane A (point k) and lane B (point k+NUM_PTS/2).
// Build option: define ROT_SYMMETRY_EN to derive lane B as the saturating
// negation of lane A, which removes the second multiplier.
module rotator_seq #(
    parameter int ROT_BITS  = 10,
    parameter int COEF_BITS = 10,
    parameter int NUM_PTS   = 20,
    parameter int PT_BITS   = $clog2(NUM_PTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ena,
    input  logic signed [ROT_BITS-1:0]  iIn0,
    input  logic signed [ROT_BITS-1:0]  qIn0,
    input  logic signed [ROT_BITS-1:0]  iIn1,
    input  logic signed [ROT_BITS-1:0]  qIn1,
    input  logic                        coefWe,
    input  logic [PT_BITS-1:0]          coefAddr,
    input  logic signed [COEF_BITS-1:0] coefReal,
    input  logic signed [COEF_BITS-1:0] coefImag,
    input  logic                        clrOverrun,
    output logic                        busy,
    output logic                        overrun,
    output logic                        outValid,
    output logic                        outSel,
    output logic [PT_BITS-1:0]          outPt,
    output logic signed [ROT_BITS-1:0]  outAReal,
    output logic signed [ROT_BITS-1:0]  outAImag,
    output logic signed [ROT_BITS-1:0]  outBReal,
    output logic signed [ROT_BITS-1:0]  outBImag
);

    localparam int HALF   = NUM_PTS / 2;
    localparam int PROD_W = ROT_BITS + COEF_BITS;
    localparam int SUM_W  = ROT_BITS + COEF_BITS + 1;

    localparam logic [PT_BITS-1:0] LAST_K    = PT_BITS'(HALF - 1);
    localparam logic [31:0]        NUM_PTS_U = 32'(NUM_PTS);

    localparam logic signed [SUM_W-1:0] RND     = SUM_W'(2 ** (COEF_BITS - 2));
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (ROT_BITS - 1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (ROT_BITS - 1)));

    localparam logic signed [ROT_BITS-1:0] ROT_MAX = {1'b0, {(ROT_BITS-1){1'b1}}};
    localparam logic signed [ROT_BITS-1:0] ROT_MIN = {1'b1, {(ROT_BITS-1){1'b0}}};

`ifndef ROT_SYMMETRY_EN
    localparam logic [PT_BITS-1:0] HALF_PT = PT_BITS'(HALF);
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Round half up at the coefficient binary point, then clamp to the output range.
    function automatic logic signed [ROT_BITS-1:0] rnd_sat(input logic signed [SUM_W-1:0] x);
        logic signed [SUM_W-1:0] v;
        v = (x + RND) >>> (COEF_BITS - 1);
        if (v > SAT_MAX)
            return ROT_MAX;
        else if (v < SAT_MIN)
            return ROT_MIN;
        else
            return v[ROT_BITS-1:0];
    endfunction

`ifdef ROT_SYMMETRY_EN
    // Negation that maps the most negative code to the most positive one.
    function automatic logic signed [ROT_BITS-1:0] neg_sat(input logic signed [ROT_BITS-1:0] v);
        return (v == ROT_MIN) ? ROT_MAX : -v;
    endfunction
`endif

    // ---------------------------------------------------------------- state
    state_t                      r_state;
    logic [PT_BITS-1:0]          r_k;
    logic                        r_sel;
    logic                        r_busy;
    logic                        r_overrun;
    logic signed [ROT_BITS-1:0]  r_i0, r_q0, r_i1, r_q1;

    logic                        r_iss_vld;
    logic [PT_BITS-1:0]          r_iss_k;
    logic                        r_iss_sel;

    logic                        r_s1_vld;
    logic [PT_BITS-1:0]          r_s1_k;
    logic                        r_s1_sel;
    logic signed [ROT_BITS-1:0]  r_s1_a, r_s1_b;
    logic signed [COEF_BITS-1:0] r_s1_ca, r_s1_da;

    logic                        r_s2_vld;
    logic [PT_BITS-1:0]          r_s2_k;
    logic                        r_s2_sel;
    logic signed [PROD_W-1:0]    r_s2_ac, r_s2_bd, r_s2_ad, r_s2_bc;

`ifndef ROT_SYMMETRY_EN
    logic signed [COEF_BITS-1:0] r_s1_cb, r_s1_db;
    logic signed [PROD_W-1:0]    r_s2_acb, r_s2_bdb, r_s2_adb, r_s2_bcb;
`endif

    logic                        r_o_vld;
    logic                        r_o_sel;
    logic [PT_BITS-1:0]          r_o_pt;
    logic signed [ROT_BITS-1:0]  r_o_ar, r_o_ai, r_o_br, r_o_bi;

    logic signed [COEF_BITS-1:0] r_tab_re [NUM_PTS];
    logic signed [COEF_BITS-1:0] r_tab_im [NUM_PTS];

    logic                        w_pipe_busy;
    logic                        w_accept;
    logic                        w_addr_ok;
    logic                        w_last_issue;
    logic signed [ROT_BITS-1:0]  w_a_re, w_a_im, w_b_re, w_b_im;

    // Something is still in flight until the product register has drained;
    // the output register alone holding the last beat does not block a new symbol.
    assign w_pipe_busy  = (r_state == ST_RUN) | r_iss_vld | r_s1_vld | r_s2_vld;
    assign w_accept     = ena & ~w_pipe_busy;
    assign w_addr_ok    = {{(32-PT_BITS){1'b0}}, coefAddr} < NUM_PTS_U;
    assign w_last_issue = (r_k == LAST_K) & r_sel;

    // Coefficient table writes, accepted only between symbols.
    // NOTE: the table has no reset on purpose: contents must survive a reset and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (coefWe && !r_busy && w_addr_ok) begin
            r_tab_re[coefAddr] <= coefReal;
            r_tab_im[coefAddr] <= coefImag;
        end
    end

    // Control FSM: sample capture, (k, sel) issue sequencing, busy and sticky overrun.
    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_sel     <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_i0      <= '0;
            r_q0      <= '0;
            r_i1      <= '0;
            r_q1      <= '0;
            r_iss_vld <= 1'b0;
            r_iss_k   <= '0;
            r_iss_sel <= 1'b0;
        end else begin
            r_busy <= w_accept | w_pipe_busy;

            // A strobe that cannot be accepted sets the flag; setting beats clearing.
            if (ena && !w_accept)
                r_overrun <= 1'b1;
            else if (clrOverrun)
                r_overrun <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_iss_vld <= 1'b0;
                    if (w_accept) begin
                        r_i0    <= iIn0;
                        r_q0    <= qIn0;
                        r_i1    <= iIn1;
                        r_q1    <= qIn1;
                        r_k     <= '0;
                        r_sel   <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_iss_vld <= 1'b1;
                    r_iss_k   <= r_k;
                    r_iss_sel <= r_sel;
                    r_sel     <= ~r_sel;
                    if (r_sel)
                        r_k <= r_k + 1'b1;
                    if (w_last_issue)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: table read and operand register (selected sample plus coefficients).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld <= 1'b0;
            r_s1_k   <= '0;
            r_s1_sel <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_ca  <= '0;
            r_s1_da  <= '0;
`ifndef ROT_SYMMETRY_EN
            r_s1_cb  <= '0;
            r_s1_db  <= '0;
`endif
        end else begin
            r_s1_vld <= r_iss_vld;
            if (r_iss_vld) begin
                r_s1_k   <= r_iss_k;
                r_s1_sel <= r_iss_sel;
                r_s1_a   <= r_iss_sel ? r_i1 : r_i0;
                r_s1_b   <= r_iss_sel ? r_q1 : r_q0;
                r_s1_ca  <= r_tab_re[r_iss_k];
                r_s1_da  <= r_tab_im[r_iss_k];
`ifndef ROT_SYMMETRY_EN
                r_s1_cb  <= r_tab_re[r_iss_k + HALF_PT];
                r_s1_db  <= r_tab_im[r_iss_k + HALF_PT];
`endif
            end
        end
    end

    // Stage 2: the four partial products of each complex multiply, full precision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_vld <= 1'b0;
            r_s2_k   <= '0;
            r_s2_sel <= 1'b0;
            r_s2_ac  <= '0;
            r_s2_bd  <= '0;
            r_s2_ad  <= '0;
            r_s2_bc  <= '0;
`ifndef ROT_SYMMETRY_EN
            r_s2_acb <= '0;
            r_s2_bdb <= '0;
            r_s2_adb <= '0;
            r_s2_bcb <= '0;
`endif
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_k   <= r_s1_k;
                r_s2_sel <= r_s1_sel;
                r_s2_ac  <= PROD_W'(r_s1_a) * PROD_W'(r_s1_ca);
                r_s2_bd  <= PROD_W'(r_s1_b) * PROD_W'(r_s1_da);
                r_s2_ad  <= PROD_W'(r_s1_a) * PROD_W'(r_s1_da);
                r_s2_bc  <= PROD_W'(r_s1_b) * PROD_W'(r_s1_ca);
`ifndef ROT_SYMMETRY_EN
                r_s2_acb <= PROD_W'(r_s1_a) * PROD_W'(r_s1_cb);
                r_s2_bdb <= PROD_W'(r_s1_b) * PROD_W'(r_s1_db);
                r_s2_adb <= PROD_W'(r_s1_a) * PROD_W'(r_s1_db);
                r_s2_bcb <= PROD_W'(r_s1_b) * PROD_W'(r_s1_cb);
`endif
            end
        end
    end

    assign w_a_re = rnd_sat(SUM_W'(r_s2_ac) - SUM_W'(r_s2_bd));
    assign w_a_im = rnd_sat(SUM_W'(r_s2_ad) + SUM_W'(r_s2_bc));
`ifdef ROT_SYMMETRY_EN
    assign w_b_re = neg_sat(w_a_re);
    assign w_b_im = neg_sat(w_a_im);
`else
    assign w_b_re = rnd_sat(SUM_W'(r_s2_acb) - SUM_W'(r_s2_bdb));
    assign w_b_im = rnd_sat(SUM_W'(r_s2_adb) + SUM_W'(r_s2_bcb));
`endif

    // Stage 3: sum, round and saturate into the output register; holds between beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_o_vld <= 1'b0;
            r_o_sel <= 1'b0;
            r_o_pt  <= '0;
            r_o_ar  <= '0;
            r_o_ai  <= '0;
            r_o_br  <= '0;
            r_o_bi  <= '0;
        end else begin
            r_o_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_o_sel <= r_s2_sel;
                r_o_pt  <= r_s2_k;
                r_o_ar  <= w_a_re;
                r_o_ai  <= w_a_im;
                r_o_br  <= w_b_re;
                r_o_bi  <= w_b_im;
            end
        end
    end

    assign busy     = r_busy;
    assign overrun  = r_overrun;
    assign outValid = r_o_vld;
    assign outSel   = r_o_sel;
    assign outPt    = r_o_pt;
    assign outAReal = r_o_ar;
    assign outAImag = r_o_ai;
    assign outBReal = r_o_br;
    assign outBImag = r_o_bi;

endmodule

// File: tb/tb_rotator_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for rotator_seq: stimulus pushes the expected beats of each
// accepted symbol (with their arrival cycle); a monitor pops and compares.
module tb_rotator_seq;

    localparam int RB   = 10;
    localparam int CB   = 10;
    localparam int NP   = 20;
    localparam int PB   = $clog2(NP);
    localparam int HALF = NP / 2;
    localparam int SMAX = (1 << (RB - 1)) - 1;
    localparam int SMIN = -(1 << (RB - 1));

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ena;
    logic signed [RB-1:0] iIn0, qIn0, iIn1, qIn1;
    logic                 coefWe;
    logic [PB-1:0]        coefAddr;
    logic signed [CB-1:0] coefReal, coefImag;
    logic                 clrOverrun;
    logic                 busy, overrun, outValid, outSel;
    logic [PB-1:0]        outPt;
    logic signed [RB-1:0] outAReal, outAImag, outBReal, outBImag;

    rotator_seq #(
        .ROT_BITS (RB),
        .COEF_BITS(CB),
        .NUM_PTS  (NP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .iIn0      (iIn0),
        .qIn0      (qIn0),
        .iIn1      (iIn1),
        .qIn1      (qIn1),
        .coefWe    (coefWe),
        .coefAddr  (coefAddr),
        .coefReal  (coefReal),
        .coefImag  (coefImag),
        .clrOverrun(clrOverrun),
        .busy      (busy),
        .overrun   (overrun),
        .outValid  (outValid),
        .outSel    (outSel),
        .outPt     (outPt),
        .outAReal  (outAReal),
        .outAImag  (outAImag),
        .outBReal  (outBReal),
        .outBImag  (outBImag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int sel;
        int pt;
        int ar;
        int ai;
        int br;
        int bi;
    } beat_t;

    beat_t sb[$];
    int    tab_re[NP];
    int    tab_im[NP];
    int    last_e0 = -1000;
    int    exp_ovr = 0;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference arithmetic: exact product, round half up, clamp.
    function automatic int rnd_sat(input int x);
        int v;
        v = (x + (1 << (CB - 2))) >>> (CB - 1);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic int neg_sat(input int v);
        return (v == SMIN) ? SMAX : -v;
    endfunction

    function automatic int rnd_real(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    // The device is busy in the cycle after edge e when a symbol accepted at
    // last_e0 still has beats in flight (last beat ends at last_e0+NP+4).
    function automatic int busy_at(input int e);
        return (e >= last_e0 && e <= last_e0 + NP + 3) ? 1 : 0;
    endfunction

    task automatic push_symbol(input int e0, input int i0, input int q0, input int i1, input int q1);
        beat_t b;
        int a, bq;
        for (int n = 0; n < NP; n++) begin
            b.pt  = n / 2;
            b.sel = n % 2;
            a     = (b.sel == 1) ? i1 : i0;
            bq    = (b.sel == 1) ? q1 : q0;
            b.ar  = rnd_sat(a * tab_re[b.pt] - bq * tab_im[b.pt]);
            b.ai  = rnd_sat(a * tab_im[b.pt] + bq * tab_re[b.pt]);
`ifdef ROT_SYMMETRY_EN
            b.br  = neg_sat(b.ar);
            b.bi  = neg_sat(b.ai);
`else
            b.br  = rnd_sat(a * tab_re[b.pt + HALF] - bq * tab_im[b.pt + HALF]);
            b.bi  = rnd_sat(a * tab_im[b.pt + HALF] + bq * tab_re[b.pt + HALF]);
`endif
            b.cyc = e0 + 4 + n;
            sb.push_back(b);
        end
    endtask

    task automatic do_symbol(input int i0, input int q0, input int i1, input int q1, input int clr);
        int e;
        @(negedge clk);
        iIn0       = RB'(i0);
        qIn0       = RB'(q0);
        iIn1       = RB'(i1);
        qIn1       = RB'(q1);
        ena        = 1'b1;
        clrOverrun = clr[0];
        e          = cyc + 1;
        if (busy_at(e) == 0) begin
            push_symbol(e, i0, q0, i1, q1);
            last_e0 = e;
            if (clr != 0) exp_ovr = 0;
        end else begin
            exp_ovr = 1;
        end
        @(negedge clk);
        ena        = 1'b0;
        clrOverrun = 1'b0;
        check("overrun_after_ena", int'(overrun), exp_ovr);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clrOverrun = 1'b1;
        exp_ovr    = 0;
        @(negedge clk);
        clrOverrun = 1'b0;
        check("overrun_after_clr", int'(overrun), exp_ovr);
    endtask

    task automatic write_coef(input int addr, input int re, input int im);
        int e;
        @(negedge clk);
        coefWe   = 1'b1;
        coefAddr = PB'(addr);
        coefReal = CB'(re);
        coefImag = CB'(im);
        e        = cyc + 1;
        if (busy_at(e - 1) == 0 && addr < NP) begin
            tab_re[addr] = re;
            tab_im[addr] = im;
        end
        @(negedge clk);
        coefWe = 1'b0;
    endtask

    // Asserts reset immediately, checks every output cleared, releases on a falling edge.
    task automatic apply_reset();
        reset = 1'b1;
        sb.delete();
        last_e0 = -1000;
        exp_ovr = 0;
        #1;
        check("rst_ctrl", int'({busy, overrun, outValid, outSel, outPt}), 0);
        check("rst_lane_a", int'({outAReal, outAImag}), 0);
        check("rst_lane_b", int'({outBReal, outBImag}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (NP + 6) @(negedge clk);
    endtask

    function automatic int rnd_sample();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return SMIN;
        if (r == 1) return SMAX;
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    // Monitor: busy every cycle, and each presented beat against the scoreboard head.
    initial begin
        beat_t b;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                check("busy", int'(busy), busy_at(cyc));
                if (outValid) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat at cycle %0d: got outValid=1, expected no beat", cyc);
                    end else begin
                        b = sb.pop_front();
                        check("beat_cycle", cyc, b.cyc);
                        check("beat_sel", int'(outSel), b.sel);
                        check("beat_pt", int'(outPt), b.pt);
                        check("beat_a_re", int'(outAReal), b.ar);
                        check("beat_a_im", int'(outAImag), b.ai);
                        check("beat_b_re", int'(outBReal), b.br);
                        check("beat_b_im", int'(outBImag), b.bi);
                    end
                end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    b = sb.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_beat at cycle %0d: got outValid=0, expected beat pt=%0d sel=%0d", cyc, b.pt, b.sel);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        real ang;
        int  e0;
        reset      = 1'b0;
        ena        = 1'b0;
        iIn0       = '0;
        qIn0       = '0;
        iIn1       = '0;
        qIn1       = '0;
        coefWe     = 1'b0;
        coefAddr   = '0;
        coefReal   = '0;
        coefImag   = '0;
        clrOverrun = 1'b0;
        for (int k = 0; k < NP; k++) begin
            tab_re[k] = 0;
            tab_im[k] = 0;
        end
        #2;
        apply_reset();

        // Phase table 511*e^(-j*2*pi*k/NP).
        for (int k = 0; k < NP; k++) begin
            ang = 2.0 * 3.14159265358979 * k / NP;
            write_coef(k, rnd_real(511.0 * $cos(ang)), rnd_real(-511.0 * $sin(ang)));
        end
        write_coef(NP + 5, 100, 100);

        // Basic product and sequencing.
        do_symbol(256, 0, rnd_sample(), rnd_sample(), 0);
        wait_idle();

        // Saturation on sample 1 at point 3.
        write_coef(3, 511, 511);
        do_symbol(rnd_sample(), rnd_sample(), -512, -512, 0);
        wait_idle();

        // Overrun: second strobe mid-symbol, clear, then set-and-clear together.
        do_symbol(256, 0, 100, -100, 0);
        e0 = last_e0;
        repeat (3) @(negedge clk);
        do_symbol(-300, 200, 50, 50, 0);
        check("overrun_strobe_ignored", last_e0, e0);
        clr_pulse();
        do_symbol(1, 1, 1, 1, 1);
        clr_pulse();
        wait_idle();

        // Coefficient write during a symbol is ignored.
        do_symbol(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), 0);
        repeat (3) @(negedge clk);
        write_coef(0, 0, 0);
        wait_idle();
        do_symbol(256, 0, rnd_sample(), rnd_sample(), 0);
        wait_idle();

        // Reset during beat 7, then a full stream with the retained table.
        do_symbol(256, 0, 300, -200, 0);
        repeat (11) @(negedge clk);
        check("beat7_present", int'(outValid), 1);
        check("beat7_pt", int'(outPt), 3);
        apply_reset();
        do_symbol(256, 0, 300, -200, 0);
        wait_idle();

        // Randomized symbols with interleaved table updates.
        for (int s = 0; s < 10; s++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                write_coef(int'($urandom_range(0, 2 ** PB - 1)),
                           int'($urandom_range(0, 1023)) - 512,
                           int'($urandom_range(0, 1023)) - 512);
            do_symbol(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), 0);
            repeat (NP + 4 + int'($urandom_range(2, 5))) @(negedge clk);
        end

        wait_idle();
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
